// File: rtl/mux_2_1_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// mux_2_1_rr_arbiter_if
//   One valid/ready packet channel. It carries the beat payload plus the
//   end-of-packet marker. The arbiter uses one instance per requester and one
//   for its output channel.
//
//   valid  : beat valid            (master -> slave)
//   data   : beat payload, DW bits (master -> slave)
//   last   : final beat of packet  (master -> slave)
//   ready  : beat accepted         (slave  -> master)
//   A beat transfers on a rising clock edge where valid & ready are both 1.
// ----------------------------------------------------------------------------
interface mux_2_1_rr_arbiter_if #(
    parameter int DW = 8
);
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
    logic          ready;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/mux_2_1_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux_2_1_rr_arbiter
//   Round-robin, packet-locked arbiter in front of a shared 2:1 data path.
//   Only one requester owns the output at a time. Ownership lasts from the
//   first beat of a packet until its last beat transfers, so packets from the
//   two requesters never interleave. Between two packets there is always one
//   IDLE cycle.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     req0   : requester 0 channel (slave side: valid/data/last in, ready out)
//     req1   : requester 1 channel (slave side)
//     out    : output channel (master side: valid/data/last out, ready in)
//     sel    : registered mux select, 0 = requester 0, 1 = requester 1
//     grant  : registered one-hot owner, 2'b00 while idle
// ----------------------------------------------------------------------------
module mux_2_1_rr_arbiter #(
    parameter int DW = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mux_2_1_rr_arbiter_if.slave         req0,
    mux_2_1_rr_arbiter_if.slave         req1,
    mux_2_1_rr_arbiter_if.master        out,
    output logic                        sel,
    output logic [1:0]                  grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    // Requester that most recently completed a packet. It loses a tie.
    logic          last_served;
    logic [DW-1:0] mux_data;

    // ------------------------------------------------------------------------
    // Ownership FSM. sel and grant are registered together with the state, so
    // they decode from the state alone and never glitch with the inputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all sequential state uses non-blocking assignments, so
            // every register samples pre-edge values no matter how the
            // statements in this block are ordered.
            state       <= IDLE;
            last_served <= 1'b1;
            sel         <= 1'b0;
            grant       <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    // req0 wins when it is alone, or on a tie after req1 was
                    // served last.
                    if (req0.valid && (!req1.valid || last_served)) begin
                        state <= OWN0;
                        sel   <= 1'b0;
                        grant <= 2'b01;
                    end else if (req1.valid) begin
                        state <= OWN1;
                        sel   <= 1'b1;
                        grant <= 2'b10;
                    end
                end
                OWN0: begin
                    // Release only when the last beat actually transfers. A
                    // gap in valid mid-packet keeps the lock.
                    if (req0.valid && out.ready && req0.last) begin
                        state       <= IDLE;
                        last_served <= 1'b0;
                        sel         <= 1'b0;
                        grant       <= 2'b00;
                    end
                end
                OWN1: begin
                    if (req1.valid && out.ready && req1.last) begin
                        state       <= IDLE;
                        last_served <= 1'b1;
                        sel         <= 1'b0;
                        grant       <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    sel   <= 1'b0;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Data path and handshake. out.valid depends only on the state and the
    // owner's valid, never on out.ready. out.ready passes straight through to
    // the owner's ready.
    // ------------------------------------------------------------------------
    assign mux_data = sel ? req1.data : req0.data;
    assign out.data = mux_data;

    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no state leaves a signal unassigned and no latch is inferred.
        out.valid  = 1'b0;
        out.last   = 1'b0;
        req0.ready = 1'b0;
        req1.ready = 1'b0;
        unique case (state)
            OWN0: begin
                out.valid  = req0.valid;
                out.last   = req0.last;
                req0.ready = out.ready;
            end
            OWN1: begin
                out.valid  = req1.valid;
                out.last   = req1.last;
                req1.ready = out.ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mux_2_1_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux_2_1_rr_arbiter
//   Self-checking bench for mux_2_1_rr_arbiter: a directed vector table,
//   hand-written multi-cycle sequences, and a randomized run against a
//   behavioural ownership model.
// ----------------------------------------------------------------------------
module tb_mux_2_1_rr_arbiter;

    localparam int DW = 8;

    logic       clk;
    logic       rst_n;
    logic       sel;
    logic [1:0] grant;

    mux_2_1_rr_arbiter_if #(.DW(DW)) req0_if ();
    mux_2_1_rr_arbiter_if #(.DW(DW)) req1_if ();
    mux_2_1_rr_arbiter_if #(.DW(DW)) out_if  ();

    mux_2_1_rr_arbiter #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0_if),
        .req1  (req1_if),
        .out   (out_if),
        .sel   (sel),
        .grant (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Absolute time bound on the whole run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [1:0] g, input logic ov,
                              input logic [DW-1:0] od, input logic ol,
                              input logic r0, input logic r1, input logic chk_data);
        check({name, ".grant"}, 32'(grant), 32'(g));
        // A one-hot owner implies sel; idle implies sel=0.
        check({name, ".sel"}, 32'(sel), 32'(g[1]));
        check({name, ".out_valid"}, 32'(out_if.valid), 32'(ov));
        check({name, ".req0_ready"}, 32'(req0_if.ready), 32'(r0));
        check({name, ".req1_ready"}, 32'(req1_if.ready), 32'(r1));
        if (chk_data) begin
            check({name, ".out_data"}, 32'(out_if.data), 32'(od));
            check({name, ".out_last"}, 32'(out_if.last), 32'(ol));
        end
    endtask

    task automatic drive(input logic v0, input logic [DW-1:0] d0, input logic l0,
                         input logic v1, input logic [DW-1:0] d1, input logic l1,
                         input logic ordy);
        req0_if.valid = v0;
        req0_if.data  = d0;
        req0_if.last  = l0;
        req1_if.valid = v1;
        req1_if.data  = d1;
        req1_if.last  = l1;
        out_if.ready  = ordy;
    endtask

    // Check at the falling edge, then move to just after the next rising edge.
    task automatic cyc(input string name, input logic [1:0] g, input logic ov,
                       input logic [DW-1:0] od, input logic ol,
                       input logic r0, input logic r1, input logic chk_data);
        @(negedge clk);
        check_outs(name, g, ov, od, ol, r0, r1, chk_data);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table: one record per cycle, applied from a fresh reset.
    // ------------------------------------------------------------------------
    typedef struct {
        logic          v0;
        logic [DW-1:0] d0;
        logic          l0;
        logic          v1;
        logic [DW-1:0] d1;
        logic          l1;
        logic          ordy;
        logic [1:0]    g;
        logic          ov;
        logic [DW-1:0] od;
        logic          ol;
        logic          r0;
        logic          r1;
    } vec_t;

    function automatic vec_t mk(input logic v0, input logic [DW-1:0] d0, input logic l0,
                                input logic v1, input logic [DW-1:0] d1, input logic l1,
                                input logic ordy, input logic [1:0] g, input logic ov,
                                input logic [DW-1:0] od, input logic ol,
                                input logic r0, input logic r1);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1; v.d1 = d1; v.l1 = l1;
        v.ordy = ordy;
        v.g = g; v.ov = ov; v.od = od; v.ol = ol; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    vec_t tbl[12];

    // Behavioural model state for the random phase: -1 = nobody owns.
    int owner;
    int last_srv;

    initial begin
        // ---- 1: reset with both requesters valid --------------------------
        rst_n = 1'b0;
        drive(1'b1, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1);
        @(negedge clk);
        check_outs("reset", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        #1;

        // ---- 2 + 3: single requester, then contention ---------------------
        //                v0   d0     l0    v1   d1     l1   ordy  g      ov   od     ol   r0   r1
        tbl[0]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 2'b10, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1);
        tbl[2]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 2'b10, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1);
        tbl[3]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 2'b10, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b1);
        tbl[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 8'hB1, 1'b0, 1'b1, 8'hC1, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 8'hB1, 1'b0, 1'b1, 8'hC1, 1'b0, 1'b1, 2'b01, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b0);
        tbl[7]  = mk(1'b1, 8'hB2, 1'b1, 1'b1, 8'hC1, 1'b0, 1'b1, 2'b01, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 8'hB3, 1'b0, 1'b1, 8'hC1, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b1, 8'hB3, 1'b0, 1'b1, 8'hC1, 1'b0, 1'b1, 2'b10, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b1);
        tbl[10] = mk(1'b1, 8'hB3, 1'b0, 1'b1, 8'hC2, 1'b1, 1'b1, 2'b10, 1'b1, 8'hC2, 1'b1, 1'b0, 1'b1);
        tbl[11] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v0, tbl[i].d0, tbl[i].l0, tbl[i].v1, tbl[i].d1, tbl[i].l1, tbl[i].ordy);
            cyc($sformatf("vec%0d", i), tbl[i].g, tbl[i].ov, tbl[i].od, tbl[i].ol,
                tbl[i].r0, tbl[i].r1, tbl[i].ov);
        end

        // ---- 4: lock holds through a mid-packet valid gap -----------------
        // Table leaves the arbiter idle with req1 served last.
        drive(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc("lock_idle", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lock_beat1", 2'b01, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            cyc($sformatf("lock_gap%0d", i), 2'b01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc("lock_last", 2'b01, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 1'b1);

        // ---- 5: backpressure on a last beat -------------------------------
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        cyc("bp_idle", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("bp_hold%0d", i), 2'b10, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        out_if.ready = 1'b1;
        cyc("bp_go", 2'b10, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc("bp_after", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---- 6: asynchronous reset mid-packet -----------------------------
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b0, 1'b1);
        cyc("ar_idle", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("ar_own1", 2'b10, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("ar_async", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b0, 1'b1, 8'h66, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("ar_rel_idle", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("ar_rel_own0", 2'b01, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1);

        // ---- randomized run against the ownership model -------------------
        do_reset();
        owner    = -1;
        last_srv = 1;
        for (int n = 0; n < 3000; n++) begin
            logic          v[2];
            logic [DW-1:0] d[2];
            logic          l[2];
            logic          ordy;
            logic [1:0]    eg;
            logic          eov, eol;
            logic [DW-1:0] eod;
            logic          er[2];
            for (int k = 0; k < 2; k++) begin
                v[k] = ($urandom_range(0, 3) != 0);
                d[k] = DW'($urandom);
                l[k] = ($urandom_range(0, 2) == 0);
            end
            ordy = ($urandom_range(0, 3) != 0);
            drive(v[0], d[0], l[0], v[1], d[1], l[1], ordy);

            eg  = 2'b00;
            eov = 1'b0;
            eol = 1'b0;
            eod = '0;
            er[0] = 1'b0;
            er[1] = 1'b0;
            if (owner >= 0) begin
                eg[owner]  = 1'b1;
                eov        = v[owner];
                eod        = d[owner];
                eol        = l[owner];
                er[owner]  = ordy;
            end
            @(negedge clk);
            check_outs($sformatf("rnd%0d", n), eg, eov, eod, eol, er[0], er[1], eov);
            @(posedge clk);
            // Model update from the rules: idle picks a winner (the one not
            // served last on a tie); an owner releases after its last beat.
            if (owner < 0) begin
                if (v[0] && v[1])   owner = 1 - last_srv;
                else if (v[0])      owner = 0;
                else if (v[1])      owner = 1;
            end else if (v[owner] && ordy && l[owner]) begin
                last_srv = owner;
                owner    = -1;
            end
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
